// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-master SDRAM arbiter: state encoding and
// SDRAM word-address width.
package sdram_arb_pkg;

  // Word address is [ADR_W:1] (16-bit words, byte address bit 0 implied).
  localparam int ADR_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_rr_grant2.sv
// Two-way round-robin grant: a lone requester wins; with both requesting,
// the master that was not served last wins.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       vld
);

  // Pick the winner index combinationally from the request pair.
  always_comb begin
    vld = |req;
    if (&req) gnt = ~last;
    else      gnt = req[1];
  end

endmodule

// File: rtl/sdram_arb.sv
// Two-master arbiter in front of a single SDRAM controller port. Grants one
// master at a time, holds the SDRAM request stable until ack or timeout, and
// forces a short idle gap on sdram_stb between transactions.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int TMO = 255,
  parameter int GAP = 2
) (
  input  logic             clk_p,
  input  logic             reset,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [1:0]       m0_sel,
  input  logic [ADR_W:1]   m0_adr,
  input  logic [15:0]      m0_dat,
  output logic             m0_ack,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [1:0]       m1_sel,
  input  logic [ADR_W:1]   m1_adr,
  input  logic [15:0]      m1_dat,
  output logic             m1_ack,
  output logic [15:0]      m_dat,
  output logic             sdram_stb,
  output logic             sdram_we,
  output logic [1:0]       sdram_sel,
  output logic [ADR_W:1]   sdram_adr,
  output logic [15:0]      sdram_out,
  input  logic             sdram_ack,
  input  logic [15:0]      sdram_dat,
  input  logic             sdram_ready,
  output logic             arb_err
);

  // Terminal counts: timeout fires in the cycle whose count is TMO-1, so the
  // counter reaches TMO on the same edge that drops sdram_stb.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  localparam logic [1:0] GAP_LAST = 2'(GAP - 1);

  arb_state_t state, state_nxt;
  logic       grant;      // index of the master owning the current cycle
  logic       last;       // index of the master served most recently
  logic [7:0] cnt;        // BUSY-cycle counter for the timeout
  logic [1:0] gap_cnt;    // idle cycles spent in GAP
  logic       rr_gnt, rr_vld;
  logic       start, done, timeout;
  logic       busy_ack;

  rr_grant2 u_rr (
    .req  ({m1_stb, m0_stb}),
    .last (last),
    .gnt  (rr_gnt),
    .vld  (rr_vld)
  );

  // State register.
  // NOTE: every register here is cleared by the asynchronous reset so
  // sdram_stb drops the moment reset asserts, not at the next clock edge.
  always_ff @(posedge clk_p or posedge reset) begin
    // NOTE: non-blocking assignments keep all flops updating from the same
    // pre-edge values, regardless of block ordering.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and one-cycle control strobes.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sdram_ready && rr_vld) begin
          state_nxt = ST_BUSY;
          start     = 1'b1;
        end
      end
      ST_BUSY: begin
        // sdram_ready is deliberately ignored here: an accepted cycle runs on.
        if (sdram_ack) begin
          state_nxt = ST_GAP;
          done      = 1'b1;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ST_GAP;
          timeout   = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SDRAM request registers, grant bookkeeping and counters.
  always_ff @(posedge clk_p or posedge reset) begin
    if (reset) begin
      sdram_stb <= 1'b0;
      sdram_we  <= 1'b0;
      sdram_sel <= '0;
      sdram_adr <= '0;
      sdram_out <= '0;
      arb_err   <= 1'b0;
      cnt       <= '0;
      gap_cnt   <= '0;
      grant     <= 1'b0;
      last      <= 1'b1;   // m1 counts as last served so m0 wins first
    end else begin
      arb_err <= timeout;
      if (start) begin
        grant     <= rr_gnt;
        last      <= rr_gnt;
        sdram_stb <= 1'b1;
        sdram_we  <= rr_gnt ? m1_we  : m0_we;
        sdram_sel <= rr_gnt ? m1_sel : m0_sel;
        sdram_adr <= rr_gnt ? m1_adr : m0_adr;
        sdram_out <= rr_gnt ? m1_dat : m0_dat;
        cnt       <= '0;
      end else if (done || timeout) begin
        sdram_stb <= 1'b0;
        gap_cnt   <= '0;
        if (timeout) cnt <= cnt + 8'd1;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 8'd1;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 2'd1;
      end
    end
  end

  // Acks go only to the granted master, and only while it still requests;
  // a master that abandoned its cycle never sees the late ack. The timeout
  // ack rides on the registered arb_err pulse.
  assign busy_ack = (state == ST_BUSY) && sdram_ack;
  assign m0_ack   = m0_stb && !grant && (busy_ack || arb_err);
  assign m1_ack   = m1_stb &&  grant && (busy_ack || arb_err);
  assign m_dat    = sdram_dat;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed self-checking bench for sdram_arb (TMO=255, GAP=2).
module tb_sdram_arb;

  logic        clk_p = 1'b0;
  logic        reset;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [1:0]  m0_sel, m1_sel;
  logic [21:1] m0_adr, m1_adr;
  logic [15:0] m0_dat, m1_dat;
  logic        m0_ack, m1_ack;
  logic [15:0] m_dat;
  logic        sdram_stb, sdram_we;
  logic [1:0]  sdram_sel;
  logic [21:1] sdram_adr;
  logic [15:0] sdram_out;
  logic        sdram_ack, sdram_ready;
  logic [15:0] sdram_dat;
  logic        arb_err;

  int total = 0;
  int bad   = 0;

  sdram_arb dut (
    .clk_p(clk_p), .reset(reset),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_dat(m0_dat), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_dat(m1_dat), .m1_ack(m1_ack),
    .m_dat(m_dat),
    .sdram_stb(sdram_stb), .sdram_we(sdram_we), .sdram_sel(sdram_sel),
    .sdram_adr(sdram_adr), .sdram_out(sdram_out),
    .sdram_ack(sdram_ack), .sdram_dat(sdram_dat), .sdram_ready(sdram_ready),
    .arb_err(arb_err)
  );

  always #5 clk_p = ~clk_p;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_p);
  endtask

  // Waits (bounded) for sdram_stb high at a falling edge; lows = low samples.
  task automatic wait_rise(input string name, output int lows);
    lows = 0;
    forever begin
      @(negedge clk_p);
      if (sdram_stb) break;
      lows++;
      if (lows > 40) begin
        total++; bad++;
        $display("FAIL %s: sdram_stb never rose within 40 cycles", name);
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    {m0_stb, m0_we, m0_sel, m0_adr, m0_dat} = '0;
    {m1_stb, m1_we, m1_sel, m1_adr, m1_dat} = '0;
    sdram_ack = 1'b0; sdram_ready = 1'b0; sdram_dat = '0;
    idle(2);
    total++;
    if ({sdram_stb, sdram_we, sdram_sel, sdram_adr, sdram_out} !== '0) begin
      bad++;
      $display("FAIL reset_sdram: got stb=%b we=%b sel=%b adr=%h out=%h want all 0",
               sdram_stb, sdram_we, sdram_sel, sdram_adr, sdram_out);
    end
    total++;
    if ({arb_err, m0_ack, m1_ack} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got err/ack0/ack1=%b want 000", {arb_err, m0_ack, m1_ack});
    end
    reset = 1'b0;
    sdram_ready = 1'b1;
  endtask

  task automatic test_single_write;
    int lows;
    m0_we = 1'b1; m0_sel = 2'b11; m0_adr = 21'h000100; m0_dat = 16'h1234;
    m0_stb = 1'b1;
    sdram_dat = 16'hBEEF;
    @(negedge clk_p);
    total++;
    if ({sdram_stb, sdram_we, sdram_sel, sdram_adr, sdram_out} !==
        {1'b1, 1'b1, 2'b11, 21'h000100, 16'h1234}) begin
      bad++;
      $display("FAIL write_issue: got stb=%b we=%b sel=%b adr=%h out=%h want 1 1 11 000100 1234",
               sdram_stb, sdram_we, sdram_sel, sdram_adr, sdram_out);
    end
    total++;
    if (m_dat !== 16'hBEEF) begin
      bad++; $display("FAIL m_dat: got %h want beef", m_dat);
    end
    idle(2);
    total++;
    if ({sdram_stb, m0_ack} !== 2'b10) begin
      bad++; $display("FAIL write_hold: got stb/ack=%b want 10", {sdram_stb, m0_ack});
    end
    sdram_ack = 1'b1;
    #1;
    total++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      bad++; $display("FAIL write_ack: got ack0/ack1=%b want 10", {m0_ack, m1_ack});
    end
    @(negedge clk_p);
    total++;
    if ({sdram_stb, m0_ack} !== 2'b00) begin
      bad++; $display("FAIL write_ack_one_cycle: got stb/ack=%b want 00", {sdram_stb, m0_ack});
    end
    sdram_ack = 1'b0; m0_stb = 1'b0;
    @(negedge clk_p);
    total++;
    if (sdram_stb !== 1'b0) begin
      bad++; $display("FAIL write_gap2: got stb=%b want 0", sdram_stb);
    end
    idle(2);
  endtask

  task automatic test_round_robin;
    int lows;
    logic [21:1] want;
    test_reset();
    m0_adr = 21'h000011; m1_adr = 21'h000022;
    m0_stb = 1'b1; m1_stb = 1'b1;
    wait_rise("rr_first", lows);
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 21'h000011 : 21'h000022;
      total++;
      if (sdram_adr !== want) begin
        bad++; $display("FAIL rr_grant%0d: got adr=%h want %h", i, sdram_adr, want);
      end
      total++;
      if ({m0_ack, m1_ack} !== 2'b00) begin
        bad++; $display("FAIL rr_noack%0d: got ack0/ack1=%b want 00", i, {m0_ack, m1_ack});
      end
      sdram_ack = 1'b1;
      #1;
      total++;
      if ({m0_ack, m1_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_ack%0d: got ack0/ack1=%b", i, {m0_ack, m1_ack});
      end
      @(negedge clk_p);
      sdram_ack = 1'b0;
      if (i == 3) break;
      wait_rise("rr_next", lows);
      total++;
      if (lows != 2) begin   // GAP cycles after this one + the IDLE grant cycle
        bad++; $display("FAIL rr_gap%0d: got %0d more low cycles want 2", i, lows);
      end
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
    idle(4);
  endtask

  task automatic test_not_ready;
    int errs = 0;
    test_reset();
    sdram_ready = 1'b0;
    m1_adr = 21'h000033; m1_stb = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_p);
      if (sdram_stb !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL not_ready_hold: got stb high in %0d cycles want 0", errs);
    end
    sdram_ready = 1'b1;
    @(negedge clk_p);
    total++;
    if ({sdram_stb, sdram_adr} !== {1'b1, 21'h000033}) begin
      bad++; $display("FAIL ready_grant: got stb=%b adr=%h want 1 000033", sdram_stb, sdram_adr);
    end
    sdram_ack = 1'b1;
    @(negedge clk_p);
    sdram_ack = 1'b0; m1_stb = 1'b0;
    idle(4);
  endtask

  task automatic test_timeout;
    int highs = 0;
    int lows;
    int errs = 0;
    m0_adr = 21'h000055; m0_stb = 1'b1;
    wait_rise("tmo_rise", lows);
    while (sdram_stb && highs < 300) begin
      highs++;
      if ({arb_err, m0_ack} !== 2'b00) errs++;
      @(negedge clk_p);
    end
    total++;
    if (highs != 255) begin
      bad++; $display("FAIL tmo_length: got stb high %0d cycles want 255", highs);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL tmo_early: got %0d early err/ack cycles want 0", errs);
    end
    total++;
    if ({arb_err, m0_ack, m1_ack} !== 3'b110) begin
      bad++; $display("FAIL tmo_pulse: got err/ack0/ack1=%b want 110", {arb_err, m0_ack, m1_ack});
    end
    wait_rise("tmo_regrant", lows);
    total++;
    if (lows != 2) begin
      bad++; $display("FAIL tmo_gap: got %0d low cycles after pulse want 2", lows);
    end
    total++;
    if (arb_err !== 1'b0) begin
      bad++; $display("FAIL tmo_err_one_cycle: got %b want 0", arb_err);
    end
    sdram_ack = 1'b1;
    @(negedge clk_p);
    sdram_ack = 1'b0; m0_stb = 1'b0;
    idle(4);
  endtask

  task automatic test_drop;
    int lows;
    int errs = 0;
    m1_adr = 21'h000044; m1_stb = 1'b1;
    wait_rise("drop_rise", lows);
    m1_stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_p);
      if (sdram_stb !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL drop_hold: got stb low in %0d cycles want 0", errs);
    end
    sdram_ack = 1'b1;
    #1;
    total++;
    if ({m0_ack, m1_ack} !== 2'b00) begin
      bad++; $display("FAIL drop_ack: got ack0/ack1=%b want 00", {m0_ack, m1_ack});
    end
    @(negedge clk_p);
    sdram_ack = 1'b0;
    total++;
    if (sdram_stb !== 1'b0) begin
      bad++; $display("FAIL drop_end: got stb=%b want 0", sdram_stb);
    end
    idle(4);
  endtask

  task automatic test_reset_busy;
    int lows;
    m0_adr = 21'h000066; m0_stb = 1'b1;
    wait_rise("rst_rise", lows);
    #2 reset = 1'b1;
    #1;
    total++;
    if (sdram_stb !== 1'b0) begin
      bad++; $display("FAIL rst_async: got stb=%b want 0", sdram_stb);
    end
    m0_stb = 1'b0;
    sdram_ack = 1'b1;
    @(negedge clk_p);
    reset = 1'b0;
    @(negedge clk_p);
    #1;
    total++;
    if ({sdram_stb, m0_ack, m1_ack} !== 3'b000) begin
      bad++; $display("FAIL rst_late_ack: got stb/ack0/ack1=%b want 000", {sdram_stb, m0_ack, m1_ack});
    end
    sdram_ack = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    idle(1);
    test_single_write();
    test_round_robin();
    test_not_ready();
    test_timeout();
    test_drop();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
